// File: rtl/insn_encoder_pkg.sv
// Shared RV32I encoder definitions: kind codes, major opcodes, FSM states and
// field-packing helpers for each instruction format.
package insn_encoder_pkg;

  localparam int unsigned K_LUI    = 0;
  localparam int unsigned K_AUIPC  = 1;
  localparam int unsigned K_JAL    = 2;
  localparam int unsigned K_JALR   = 3;
  localparam int unsigned K_BRANCH = 4;
  localparam int unsigned K_LOAD   = 5;
  localparam int unsigned K_STORE  = 6;
  localparam int unsigned K_OPIMM  = 7;
  localparam int unsigned K_OP     = 8;
  localparam int unsigned K_LI     = 9;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  typedef enum logic {ST_IDLE, ST_SECOND} state_t;

  function automatic logic [31:0] enc_u(input logic [19:0] imm_hi, input logic [4:0] rd,
                                        input logic [6:0] opc);
    return {imm_hi, rd, opc};
  endfunction

  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd,
                                        input logic [6:0] opc);
    return {imm, rs1, f3, rd, opc};
  endfunction

  function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3);
    return {imm[11:5], rs2, rs1, f3, imm[4:0], OPC_STORE};
  endfunction

  // Branch/jump offsets are always even, so only bits [N:1] are carried.
  function automatic logic [31:0] enc_b(input logic [12:1] off, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3);
    return {off[12], off[10:5], rs2, rs1, f3, off[4:1], off[11], OPC_BRANCH};
  endfunction

  function automatic logic [31:0] enc_j(input logic [20:1] off, input logic [4:0] rd);
    return {off[20], off[10:1], off[11], off[19:12], rd, OPC_JAL};
  endfunction

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, OPC_OP};
  endfunction

endpackage

// File: rtl/insn_encoder_pack.sv
// Combinational packer: request fields -> first instruction word, error flag,
// and whether an LI needs a trailing ADDI word.
module insn_pack
  import insn_encoder_pkg::*;
#(
  parameter int KIND_W      = 4,
  parameter bit CHECK_RANGE = 1'b1
) (
  input  logic [KIND_W-1:0] i_kind,
  input  logic [4:0]        i_rd,
  input  logic [4:0]        i_rs1,
  input  logic [4:0]        i_rs2,
  input  logic [2:0]        i_funct3,
  input  logic [6:0]        i_funct7,
  input  logic [31:0]       i_imm,
  output logic [31:0]       o_insn,
  output logic              o_err,
  output logic              o_needs_second
);

  logic [31:0] w_kind;
  logic        w_fit12;
  logic        w_fit13;
  logic        w_fit21;
  logic [19:0] w_li_hi;

  assign w_kind  = 32'(i_kind);
  assign w_fit12 = (&i_imm[31:11]) | ~(|i_imm[31:11]);
  assign w_fit13 = (&i_imm[31:12]) | ~(|i_imm[31:12]);
  assign w_fit21 = (&i_imm[31:20]) | ~(|i_imm[31:20]);
  // Rounds the upper part so that sign-extended ADDI lo lands on the value.
  assign w_li_hi = i_imm[31:12] + {19'd0, i_imm[11]};

  always_comb begin
    o_insn         = '0;
    o_err          = 1'b0;
    o_needs_second = 1'b0;
    case (w_kind)
      K_LUI:    o_insn = enc_u(i_imm[31:12], i_rd, OPC_LUI);
      K_AUIPC:  o_insn = enc_u(i_imm[31:12], i_rd, OPC_AUIPC);
      K_JAL: begin
        o_insn = enc_j(i_imm[20:1], i_rd);
        o_err  = CHECK_RANGE && (!w_fit21 || i_imm[0]);
      end
      K_JALR: begin
        o_insn = enc_i(i_imm[11:0], i_rs1, 3'b000, i_rd, OPC_JALR);
        o_err  = CHECK_RANGE && !w_fit12;
      end
      K_BRANCH: begin
        o_insn = enc_b(i_imm[12:1], i_rs2, i_rs1, i_funct3);
        o_err  = CHECK_RANGE && (!w_fit13 || i_imm[0]);
      end
      K_LOAD: begin
        o_insn = enc_i(i_imm[11:0], i_rs1, i_funct3, i_rd, OPC_LOAD);
        o_err  = CHECK_RANGE && !w_fit12;
      end
      K_STORE: begin
        o_insn = enc_s(i_imm[11:0], i_rs2, i_rs1, i_funct3);
        o_err  = CHECK_RANGE && !w_fit12;
      end
      K_OPIMM: begin
        o_insn = enc_i(i_imm[11:0], i_rs1, i_funct3, i_rd, OPC_OPIMM);
        o_err  = CHECK_RANGE && !w_fit12;
      end
      K_OP:     o_insn = enc_r(i_funct7, i_rs2, i_rs1, i_funct3, i_rd);
      K_LI: begin
        if (w_fit12) begin
          o_insn = enc_i(i_imm[11:0], 5'd0, 3'b000, i_rd, OPC_OPIMM);
        end else begin
          o_insn         = enc_u(w_li_hi, i_rd, OPC_LUI);
          o_needs_second = (i_imm[11:0] != 12'd0);
        end
      end
      default: begin
        o_insn = '0;
        o_err  = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/insn_encoder.sv
// RV32I instruction encoder with valid/ready handshakes, one registered output
// stage and a two-state FSM that emits the ADDI half of a split LI.
module insn_encoder
  import insn_encoder_pkg::*;
#(
  parameter int KIND_W      = 4,
  parameter bit CHECK_RANGE = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [KIND_W-1:0] in_kind,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [2:0]        in_funct3,
  input  logic [6:0]        in_funct7,
  input  logic [31:0]       in_imm,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_insn,
  output logic              out_err,
  output logic              out_last
);

  state_t      r_state;
  state_t      w_state_next;
  logic        r_valid;
  logic [31:0] r_insn;
  logic        r_err;
  logic        r_last;
  logic [4:0]  r_pend_rd;
  logic [11:0] r_pend_lo;

  logic [31:0] w_pack_insn;
  logic        w_pack_err;
  logic        w_pack_second;
  logic        w_slot_free;
  logic        w_accept;
  logic        w_load;
  logic [31:0] w_insn_next;
  logic        w_err_next;
  logic        w_last_next;

  insn_pack #(
    .KIND_W      (KIND_W),
    .CHECK_RANGE (CHECK_RANGE)
  ) u_pack (
    .i_kind         (in_kind),
    .i_rd           (in_rd),
    .i_rs1          (in_rs1),
    .i_rs2          (in_rs2),
    .i_funct3       (in_funct3),
    .i_funct7       (in_funct7),
    .i_imm          (in_imm),
    .o_insn         (w_pack_insn),
    .o_err          (w_pack_err),
    .o_needs_second (w_pack_second)
  );

  assign w_slot_free = !r_valid || out_ready;
  assign in_ready    = !reset && (r_state == ST_IDLE) && w_slot_free;
  assign w_accept    = in_valid && in_ready;

  always_comb begin
    w_state_next = r_state;
    w_load       = 1'b0;
    w_insn_next  = r_insn;
    w_err_next   = r_err;
    w_last_next  = r_last;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_load      = 1'b1;
          w_insn_next = w_pack_insn;
          w_err_next  = w_pack_err;
          w_last_next = !w_pack_second;
          if (w_pack_second) begin
            w_state_next = ST_SECOND;
          end
        end
      end
      ST_SECOND: begin
        // The LUI word is always held here, so a free slot means it retires now.
        if (w_slot_free) begin
          w_load       = 1'b1;
          w_insn_next  = enc_i(r_pend_lo, r_pend_rd, 3'b000, r_pend_rd, OPC_OPIMM);
          w_err_next   = 1'b0;
          w_last_next  = 1'b1;
          w_state_next = ST_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_valid   <= 1'b0;
      r_insn    <= '0;
      r_err     <= 1'b0;
      r_last    <= 1'b0;
      r_pend_rd <= '0;
      r_pend_lo <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_load) begin
        r_valid <= 1'b1;
        r_insn  <= w_insn_next;
        r_err   <= w_err_next;
        r_last  <= w_last_next;
      end else if (out_ready) begin
        r_valid <= 1'b0;
      end
      if (w_accept && w_pack_second) begin
        r_pend_rd <= in_rd;
        r_pend_lo <= in_imm[11:0];
      end
    end
  end

  assign out_valid = r_valid;
  assign out_insn  = r_insn;
  assign out_err   = r_err;
  assign out_last  = r_last;

endmodule

// File: tb/tb_insn_encoder.sv
// Scoreboard bench for insn_encoder: directed requests push expected words,
// a negedge monitor pops and compares on every output handshake.
module tb_insn_encoder;

  localparam int KW = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [KW-1:0] in_kind = '0;
  logic [4:0]    in_rd = '0;
  logic [4:0]    in_rs1 = '0;
  logic [4:0]    in_rs2 = '0;
  logic [2:0]    in_funct3 = '0;
  logic [6:0]    in_funct7 = '0;
  logic [31:0]   in_imm = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [31:0]   out_insn;
  logic          out_err;
  logic          out_last;

  typedef struct {
    logic [31:0] insn;
    logic        err;
    logic        last;
    string       tag;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  insn_encoder #(.KIND_W(KW), .CHECK_RANGE(1'b1)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_kind   (in_kind),
    .in_rd     (in_rd),
    .in_rs1    (in_rs1),
    .in_rs2    (in_rs2),
    .in_funct3 (in_funct3),
    .in_funct7 (in_funct7),
    .in_imm    (in_imm),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_insn  (out_insn),
    .out_err   (out_err),
    .out_last  (out_last)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic push(input string tag, input logic [31:0] insn, input logic err, input logic last);
    exp_t e;
    e.insn = insn;
    e.err  = err;
    e.last = last;
    e.tag  = tag;
    q.push_back(e);
  endtask

  // Called at posedge+1; returns at posedge+1 just after the accepting edge.
  task automatic send(input int k, input logic [4:0] rd, input logic [4:0] rs1,
                      input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7,
                      input logic [31:0] imm);
    bit done = 0;
    in_valid  = 1'b1;
    in_kind   = KW'(k);
    in_rd     = rd;
    in_rs1    = rs1;
    in_rs2    = rs2;
    in_funct3 = f3;
    in_funct7 = f7;
    in_imm    = imm;
    for (int c = 0; c < 50 && !done; c++) begin
      @(negedge clk);
      if (in_ready) done = 1;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    if (!done) begin
      n_checks++;
      n_fail++;
      $display("FAIL send_timeout: kind %0d not accepted within 50 cycles", k);
    end
  endtask

  task automatic req(input string tag, input int k, input logic [4:0] rd, input logic [4:0] rs1,
                     input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7,
                     input logic [31:0] imm, input logic [31:0] e_insn, input logic e_err,
                     input logic e_last);
    push(tag, e_insn, e_err, e_last);
    send(k, rd, rs1, rs2, f3, f7, imm);
  endtask

  task automatic drain();
    bit empty = 0;
    for (int c = 0; c < 100 && !empty; c++) begin
      @(negedge clk);
      if (q.size() == 0 && !out_valid) empty = 1;
    end
    check("drain_queue_empty", 32'(q.size()), 32'd0);
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      if (q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_word: got 0x%08h with no expectation queued", out_insn);
      end else begin
        exp_t e;
        e = q.pop_front();
        check({e.tag, ".insn"}, out_insn, e.insn);
        check({e.tag, ".err"}, 32'(out_err), 32'(e.err));
        check({e.tag, ".last"}, 32'(out_last), 32'(e.last));
        $display("word %-14s insn=0x%08h err=%0b last=%0b", e.tag, out_insn, out_err, out_last);
      end
    end
  end

  initial begin
    repeat (2) @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_out_insn", out_insn, 32'd0);
    check("rst_out_err", 32'(out_err), 32'd0);
    check("rst_out_last", 32'(out_last), 32'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("post_rst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;

    // Back-to-back stream with out_ready held high.
    push("li_big_lui", 32'h123462B7, 1'b0, 1'b0);
    push("li_big_addi", 32'hFFF28293, 1'b0, 1'b1);
    send(9, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345FFF);
    req("li_neg5", 9, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFFFFFB, 32'hFFB00093, 1'b0, 1'b1);
    req("li_lui_only", 9, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h00010000, 32'h000102B7, 1'b0, 1'b1);
    req("li_2047", 9, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2047, 32'h7FF00093, 1'b0, 1'b1);
    push("li_2048_lui", 32'h000010B7, 1'b0, 1'b0);
    push("li_2048_addi", 32'h80008093, 1'b0, 1'b1);
    send(9, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048);
    req("beq_8", 4, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd8, 32'h00208463, 1'b0, 1'b1);
    req("jal_800", 2, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h800, 32'h001000EF, 1'b0, 1'b1);
    req("jal_range", 2, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h00100000, 32'h800000EF, 1'b1, 1'b1);
    req("jal_min", 2, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFF00000, 32'h800000EF, 1'b0, 1'b1);
    req("beq_odd", 4, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd3, 32'h00208163, 1'b1, 1'b1);
    req("beq_min", 4, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'hFFFFF000, 32'h80208063, 1'b0, 1'b1);
    req("beq_4096", 4, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'h00001000, 32'h80208063, 1'b1, 1'b1);
    req("kind12", 12, 5'd3, 5'd1, 5'd2, 3'd1, 7'd0, 32'h0, 32'h00000000, 1'b1, 1'b1);
    req("sub", 8, 5'd3, 5'd1, 5'd2, 3'd0, 7'h20, 32'h0, 32'h402081B3, 1'b0, 1'b1);
    req("sw", 6, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'd4, 32'h0020A223, 1'b0, 1'b1);
    req("lw_neg4", 5, 5'd5, 5'd1, 5'd0, 3'd2, 7'd0, 32'hFFFFFFFC, 32'hFFC0A283, 1'b0, 1'b1);
    req("addi_2048", 7, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048, 32'h80000093, 1'b1, 1'b1);
    req("jalr_f3", 3, 5'd1, 5'd5, 5'd0, 3'd7, 7'd0, 32'd16, 32'h010280E7, 1'b0, 1'b1);
    req("lui", 0, 5'd5, 5'd0, 5'd0, 3'd3, 7'd0, 32'hABCDE123, 32'hABCDE2B7, 1'b0, 1'b1);
    req("auipc", 1, 5'd2, 5'd0, 5'd0, 3'd0, 7'd0, 32'h00001000, 32'h00001117, 1'b0, 1'b1);
    drain();

    // Consumer stalls five cycles on the LUI half of a split LI.
    out_ready = 1'b0;
    push("stall_lui", 32'h123462B7, 1'b0, 1'b0);
    push("stall_addi", 32'hFFF28293, 1'b0, 1'b1);
    send(9, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345FFF);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("stall_valid", 32'(out_valid), 32'd1);
      check("stall_insn", out_insn, 32'h123462B7);
      check("stall_last", 32'(out_last), 32'd0);
      check("stall_in_ready", 32'(in_ready), 32'd0);
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("addi_next_valid", 32'(out_valid), 32'd1);
    check("addi_next_insn", out_insn, 32'hFFF28293);
    @(posedge clk);
    #1;
    drain();

    // Reset while the ADDI half is pending discards it.
    out_ready = 1'b0;
    send(9, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345FFF);
    @(negedge clk);
    check("second_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    check("midrst_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_in_ready_after", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1 out_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("no_addi_after_rst", 32'(out_valid), 32'd0);
    end
    @(posedge clk);
    #1;

    req("post_rst_li", 9, 5'd7, 5'd0, 5'd0, 3'd0, 7'd0, 32'd100, 32'h06400393, 1'b0, 1'b1);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/insn_encoder.md
Name: insn_encoder

Overview:
- Inverse of the decode-side immediate extractor. Takes an instruction kind, register fields, funct fields and a full 32-bit immediate, and packs them into a legal RV32I instruction word.
- Expands the LI pseudo-op into LUI+ADDI when the value needs it.
- Sits between the test/boot-ROM sequencer and instruction memory write port. Valid/ready in, valid/ready out, one registered output stage.

Parameters:
- KIND_W, 4, width of kind field
- CHECK_RANGE, 1, when 1 flag out-of-range/misaligned immediates on out_err; when 0 out_err only flags illegal kind

Ports:
- clk  in  1  clock, all logic rising-edge
- reset  in  1  synchronous, active-high
- in_valid  in  1  request valid
- in_ready  out  1  request accepted when in_valid&in_ready
- in_kind  in  KIND_W  0 LUI, 1 AUIPC, 2 JAL, 3 JALR, 4 BRANCH, 5 LOAD, 6 STORE, 7 OPIMM, 8 OP, 9 LI, 10-15 illegal
- in_rd  in  5  destination reg
- in_rs1  in  5  source 1
- in_rs2  in  5  source 2
- in_funct3  in  3  funct3 (ignored for LUI/AUIPC/JAL/LI; JALR forces 000)
- in_funct7  in  7  funct7 (OP only; OPIMM shifts use imm[11:5])
- in_imm  in  32  byte-offset/value immediate, two's complement; LUI/AUIPC take the value already shifted (low 12 bits ignored)
- out_valid  out  1  out_insn valid
- out_ready  in  1  consumer accepts
- out_insn  out  32  encoded instruction
- out_err  out  1  word is illegal/out-of-range, qualified by out_valid
- out_last  out  1  final word of the request (0 only on LUI half of two-word LI)

Behaviour:
- Clocking/reset: one clock `clk`; reset is synchronous and active-high, port `reset`.
- Reset values: out_valid=0, out_insn=0, out_err=0, out_last=0, FSM=IDLE, pending regs cleared. in_ready is 0 during reset.
- Reset mid-operation drops any pending second LI word. No partial word is emitted after reset.
- FSM states: IDLE, SECOND.
- in_ready=1 iff state==IDLE && (!out_valid || out_ready).
- Accept in IDLE: encode and load the output register the next cycle. Latency is 1 cycle from accept to out_valid.
- Output register holds out_insn/out_err/out_last stable while out_valid&&!out_ready.
- Encodings (opcode[1:0]=11):
  - U: imm[31:12]|rd|opc
  - J: imm[20|10:1|11|19:12]|rd|1101111
  - I: imm[11:0]|rs1|f3|rd|opc
  - S: imm[11:5]|rs2|rs1|f3|imm[4:0]|0100011
  - B: imm[12|10:5]|rs2|rs1|f3|imm[4:1|11]|1100011
  - R: f7|rs2|rs1|f3|rd|0110011
- LI, with hi=(imm+0x800)>>12 (32-bit wrap) and lo=imm[11:0]:
  - If imm sign-fits 12 bits: one word ADDI rd,x0,lo, out_last=1.
  - Else if lo==0: one word LUI rd,hi, out_last=1.
  - Else: LUI rd,hi (out_last=0), then FSM->SECOND. The ADDI rd,rd,lo word (out_last=1) is loaded on the cycle the LUI is consumed, then ->IDLE.
  - No new request is accepted in SECOND.
- Range errors (CHECK_RANGE=1), which set out_err=1 while still emitting the truncated encoding:
  - I/S: imm outside [-2048,2047].
  - B: imm outside [-4096,4094] or imm[0]=1.
  - J: imm outside [-2^20,2^20-2] or imm[0]=1.
- Illegal kind: out_insn=0, out_err=1, out_last=1, regardless of CHECK_RANGE.
- Simultaneous out_ready and in_valid in IDLE: old word retires, new word loads the same edge, no bubble.

Decomposition:
- Shared package: kind codes, 7-bit opcode constants (same set as the decode side), and function-local bit-slice helpers for B/J/S immediates.
- One natural sub-module, insn_pack: purely combinational kind+fields -> {insn, err, needs_second}. insn_encoder owns the FSM and output register.

Test Plan:
- LI rd=5 imm=0x12345FFF -> words 0x123462B7 (last=0), then 0xFFF28293 (last=1); err=0.
- LI rd=1 imm=-5 -> single 0xFFB00093, last=1. LI rd=5 imm=0x00010000 -> single 0x000102B7.
- BRANCH f3=000 rs1=1 rs2=2 imm=8 -> 0x00208463. JAL rd=1 imm=0x800 -> 0x001000EF.
- JAL imm=0x100000 -> err=1. BRANCH imm=3 -> err=1. kind=12 -> insn=0, err=1.
- out_ready low 5 cycles during a two-word LI -> LUI word held stable, in_ready=0 throughout, ADDI follows exactly one cycle after the LUI handshake.
- Reset asserted while state=SECOND -> next cycle out_valid=0, in_ready=1 after reset release, no ADDI emitted.
